// File: rtl/regfile_pkg.sv
// Shared constants, clear FSM state type and write-port priority helper
// for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 19;
    localparam int unsigned DEPTH_DEF  = 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

    // Source selected for a register location or a read bypass
    typedef enum logic [1:0] {
        SEL_STORE,
        SEL_A,
        SEL_B
    } wsel_e;

    // Port A (ALU) has priority over port B (load return) on the same address
    function automatic wsel_e wr_sel(input logic a_hit, input logic b_hit);
        if (a_hit) begin
            return SEL_A;
        end else if (b_hit) begin
            return SEL_B;
        end
        return SEL_STORE;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Sequential bank-clear engine: walks every register address once,
// emitting a clear-write strobe per cycle, then pulses done.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;

    // State, counter and done-pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clr_we_o   = (state_q == CLEAR);
    assign clr_addr_o = cnt_q;
    assign busy_o     = (state_q == CLEAR);
    assign done_o     = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports with same-cycle
// write bypass, two write ports (A has priority), per-register busy
// scoreboard and a sequential bank-clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              wr_collision
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              coll_q, coll_d;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_active;

    logic              host_ok;
    logic              wa_ok, wb_ok, bs_ok;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .start_i    (clear_start),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (clr_active),
        .done_o     (clear_done)
    );

    assign clear_busy = clr_active;

    // Host-side enables: suppressed during a clear and for the hardwired zero register
    always_comb begin
        host_ok = ~clr_active;
        wa_ok   = wa_en    & host_ok & ~(ZERO_REG && (wa_addr   == '0));
        wb_ok   = wb_en    & host_ok & ~(ZERO_REG && (wb_addr   == '0));
        bs_ok   = busy_set & host_ok & ~(ZERO_REG && (busy_addr == '0));
        coll_d  = wa_en & wb_en & host_ok & (wa_addr == wb_addr);
    end

    // Bank and scoreboard next state; clear-engine write overrides host activity
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            case (wr_sel(wa_ok && (wa_addr == ADDR_W'(i)),
                         wb_ok && (wb_addr == ADDR_W'(i))))
                SEL_A:   regs_d[i] = wa_data;
                SEL_B:   regs_d[i] = wb_data;
                default: regs_d[i] = regs_q[i];
            endcase
            // A dropped port-B write on a collision still retires the load
            if (wb_ok && (wb_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (bs_ok && (busy_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
            if (clr_we && (clr_addr == ADDR_W'(i))) begin
                regs_d[i] = '0;
                busy_d[i] = 1'b0;
            end
        end
    end

    // Bank, scoreboard and collision-pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            coll_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            coll_q <= coll_d;
        end
    end

    assign wr_collision = coll_q;

    // Read port 1 with same-cycle write bypass
    always_comb begin
        case (wr_sel(wa_ok && (wa_addr == rd_addr1), wb_ok && (wb_addr == rd_addr1)))
            SEL_A:   rd_data1 = wa_data;
            SEL_B:   rd_data1 = wb_data;
            default: rd_data1 = regs_q[rd_addr1];
        endcase
        rd_busy1 = busy_q[rd_addr1];
    end

    // Read port 2 with same-cycle write bypass
    always_comb begin
        case (wr_sel(wa_ok && (wa_addr == rd_addr2), wb_ok && (wb_addr == rd_addr2)))
            SEL_A:   rd_data2 = wa_data;
            SEL_B:   rd_data2 = wb_data;
            default: rd_data2 = regs_q[rd_addr2];
        endcase
        rd_busy2 = busy_q[rd_addr2];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares.
module tb_regfile_mp;

    localparam int DW = 19;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rd_addr1, rd_addr2, wa_addr, wb_addr, busy_addr;
    logic [DW-1:0] wa_data, wb_data;
    logic          wa_en, wb_en, busy_set, clear_start;

    logic [DW-1:0] rd_data1, rd_data2, z_rd_data1, z_rd_data2;
    logic          rd_busy1, rd_busy2, z_rd_busy1, z_rd_busy2;
    logic          clear_busy, clear_done, wr_collision;
    logic          z_clear_busy, z_clear_done, z_wr_collision;

    regfile_mp #(.DATA_W(DW), .DEPTH(8), .ZERO_REG(1'b0)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done), .wr_collision(wr_collision)
    );

    regfile_mp #(.DATA_W(DW), .DEPTH(8), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
        .rd_busy1(z_rd_busy1), .rd_busy2(z_rd_busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .clear_start(clear_start), .clear_busy(z_clear_busy),
        .clear_done(z_clear_done), .wr_collision(z_wr_collision)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {S_RD1, S_RD2, S_BUSY1, S_BUSY2, S_CBUSY, S_CDONE, S_COLL, S_ZRD1, S_ZBUSY1} sig_e;

    typedef struct {
        int unsigned   cyc;
        sig_e          sel;
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [DW-1:0] probe(sig_e s);
        case (s)
            S_RD1:    return rd_data1;
            S_RD2:    return rd_data2;
            S_BUSY1:  return DW'(rd_busy1);
            S_BUSY2:  return DW'(rd_busy2);
            S_CBUSY:  return DW'(clear_busy);
            S_CDONE:  return DW'(clear_done);
            S_COLL:   return DW'(wr_collision);
            S_ZRD1:   return z_rd_data1;
            S_ZBUSY1: return DW'(z_rd_busy1);
            default:  return 'x;
        endcase
    endfunction

    task automatic expect_v(input sig_e s, input logic [DW-1:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = s;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (probe(mon_e.sel) !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", mon_e.name, probe(mon_e.sel), mon_e.exp, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; busy_set = 1'b0; clear_start = 1'b0;
    endtask

    initial begin
        idle();
        rd_addr1 = '0; rd_addr2 = '0; wa_addr = '0; wb_addr = '0; busy_addr = '0;
        wa_data = '0; wb_data = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        expect_v(S_RD1, 19'h0, "reset_rd1");
        expect_v(S_RD2, 19'h0, "reset_rd2");
        expect_v(S_BUSY1, 19'h0, "reset_busy");
        expect_v(S_CBUSY, 19'h0, "reset_clear_busy");
        expect_v(S_CDONE, 19'h0, "reset_clear_done");
        expect_v(S_COLL, 19'h0, "reset_collision");

        // Port A write r3, bypass visible same cycle
        tick();
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 19'h7FFFF;
        rd_addr1 = 3'd5; rd_addr2 = 3'd3;
        expect_v(S_RD1, 19'h0, "r5_untouched");
        expect_v(S_RD2, 19'h7FFFF, "bypass_a_r3");
        tick(); idle();
        rd_addr1 = 3'd3; rd_addr2 = 3'd3;
        expect_v(S_RD1, 19'h7FFFF, "r3_port1");
        expect_v(S_RD2, 19'h7FFFF, "r3_port2");
        tick();
        rd_addr1 = 3'd5;
        expect_v(S_RD1, 19'h0, "r5_zero");

        // Collision on r2: A wins, pulse next cycle only
        tick();
        wa_en = 1'b1; wa_addr = 3'd2; wa_data = 19'h00011;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 19'h00022;
        rd_addr1 = 3'd2; rd_addr2 = 3'd2;
        expect_v(S_RD1, 19'h00011, "coll_bypass_a_wins");
        expect_v(S_COLL, 19'h0, "coll_not_yet");
        tick(); idle();
        expect_v(S_RD1, 19'h00011, "coll_stored_a");
        expect_v(S_COLL, 19'h1, "coll_pulse");
        tick();
        expect_v(S_COLL, 19'h0, "coll_one_cycle");
        expect_v(S_RD2, 19'h00011, "coll_stored_a_p2");

        // Port B bypass alone, simultaneous writes to distinct addresses
        tick();
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 19'h0ABCD;
        wa_en = 1'b1; wa_addr = 3'd1; wa_data = 19'h00111;
        rd_addr1 = 3'd5; rd_addr2 = 3'd1;
        expect_v(S_RD1, 19'h0ABCD, "bypass_b_r5");
        expect_v(S_RD2, 19'h00111, "bypass_a_r1");
        tick(); idle();
        expect_v(S_RD1, 19'h0ABCD, "stored_b_r5");
        expect_v(S_RD2, 19'h00111, "stored_a_r1");
        expect_v(S_COLL, 19'h0, "no_coll_distinct");

        // Scoreboard: set r4, retire with port-B write three cycles later
        tick();
        busy_set = 1'b1; busy_addr = 3'd4; rd_addr1 = 3'd4;
        expect_v(S_BUSY1, 19'h0, "busy_not_yet");
        tick(); idle();
        expect_v(S_BUSY1, 19'h1, "busy_r4_t1");
        tick();
        expect_v(S_BUSY1, 19'h1, "busy_r4_t2");
        tick();
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 19'h12345;
        expect_v(S_BUSY1, 19'h1, "busy_r4_t3");
        expect_v(S_RD1, 19'h12345, "bypass_b_r4");
        tick(); idle();
        expect_v(S_BUSY1, 19'h0, "busy_r4_cleared");
        expect_v(S_RD1, 19'h12345, "stored_r4");

        // Set and clear of r6 in one cycle: set wins; port A leaves busy alone
        tick();
        busy_set = 1'b1; busy_addr = 3'd6;
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 19'h00666;
        rd_addr2 = 3'd6;
        expect_v(S_RD2, 19'h00666, "bypass_b_r6");
        expect_v(S_BUSY2, 19'h0, "busy_r6_before");
        tick(); idle();
        expect_v(S_BUSY2, 19'h1, "busy_set_wins");
        expect_v(S_RD2, 19'h00666, "stored_r6");
        tick();
        wa_en = 1'b1; wa_addr = 3'd6; wa_data = 19'h00777;
        expect_v(S_RD2, 19'h00777, "bypass_a_r6");
        tick(); idle();
        expect_v(S_BUSY2, 19'h1, "busy_kept_by_a");
        expect_v(S_RD2, 19'h00777, "stored_a_r6");

        // Fill all registers
        for (int i = 0; i < 8; i++) begin
            tick();
            wa_en = 1'b1; wa_addr = AW'(i); wa_data = 19'h10000 + DW'(i);
        end
        tick(); idle();
        busy_set = 1'b1; busy_addr = 3'd1;
        rd_addr1 = 3'd7; rd_addr2 = 3'd0;
        expect_v(S_RD1, 19'h10007, "fill_r7");
        expect_v(S_RD2, 19'h10000, "fill_r0");

        // Bank clear
        tick(); idle();
        clear_start = 1'b1; rd_addr1 = 3'd1;
        expect_v(S_BUSY1, 19'h1, "busy_r1_pre_clear");
        expect_v(S_CBUSY, 19'h0, "clear_busy_not_yet");
        for (int k = 1; k <= 8; k++) begin
            tick(); idle();
            expect_v(S_CBUSY, 19'h1, "clear_busy_high");
            expect_v(S_CDONE, 19'h0, "clear_done_low");
            if (k == 1) expect_v(S_RD2, 19'h10000, "clear_r0_pending");
            if (k == 2) expect_v(S_RD2, 19'h0, "clear_r0_done");
            if (k == 3) begin
                wa_en = 1'b1; wa_addr = 3'd5; wa_data = 19'h7AAAA;
                wb_en = 1'b1; wb_addr = 3'd5; wb_data = 19'h7BBBB;
                clear_start = 1'b1;
                rd_addr1 = 3'd5;
                expect_v(S_RD1, 19'h10005, "clear_no_bypass");
            end
            if (k == 4) begin
                expect_v(S_RD1, 19'h10005, "clear_write_dropped");
                expect_v(S_COLL, 19'h0, "clear_no_collision");
            end
            if (k == 7) expect_v(S_RD1, 19'h0, "clear_r5_done");
        end
        tick(); idle();
        expect_v(S_CBUSY, 19'h0, "clear_busy_end");
        expect_v(S_CDONE, 19'h1, "clear_done_pulse");
        wa_en = 1'b1; wa_addr = 3'd7; wa_data = 19'h00777; rd_addr2 = 3'd7;
        expect_v(S_RD2, 19'h00777, "write_in_done_cycle");
        tick(); idle();
        expect_v(S_CDONE, 19'h0, "clear_done_once");
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = AW'(i);
            expect_v(S_RD1, (i == 7) ? 19'h00777 : 19'h0, "post_clear_data");
            expect_v(S_BUSY1, 19'h0, "post_clear_busy");
            tick();
        end

        // Zero register behaviour (second instance), contrasted with the normal one
        wa_en = 1'b1; wa_addr = 3'd0; wa_data = 19'h55555; rd_addr1 = 3'd0;
        expect_v(S_RD1, 19'h55555, "r0_bypass_normal");
        expect_v(S_ZRD1, 19'h0, "zr0_no_bypass");
        tick(); idle();
        busy_set = 1'b1; busy_addr = 3'd0;
        expect_v(S_RD1, 19'h55555, "r0_written_normal");
        expect_v(S_ZRD1, 19'h0, "zr0_reads_zero");
        tick(); idle();
        expect_v(S_BUSY1, 19'h1, "r0_busy_normal");
        expect_v(S_ZBUSY1, 19'h0, "zr0_busy_zero");
        expect_v(S_ZRD1, 19'h0, "zr0_still_zero");

        // Reset in cycle 4 of a clear
        tick();
        wa_en = 1'b1; wa_addr = 3'd7; wa_data = 19'h1ABCD;
        tick(); idle();
        clear_start = 1'b1; rd_addr1 = 3'd7;
        expect_v(S_RD1, 19'h1ABCD, "r7_before_clear");
        for (int k = 1; k <= 4; k++) begin
            tick(); idle();
            if (k < 4) expect_v(S_CBUSY, 19'h1, "clear2_busy");
        end
        rst = 1'b1;
        #1;
        expect_v(S_CBUSY, 19'h0, "rst_mid_clear_busy");
        expect_v(S_CDONE, 19'h0, "rst_mid_clear_done");
        tick();
        rst = 1'b0;
        expect_v(S_RD1, 19'h0, "r7_after_reset");
        expect_v(S_CBUSY, 19'h0, "clear_busy_after_reset");
        tick(); tick();

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            errors += sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the next generation of the 8 x 19-bit, two-read/one-write register bank used by the datapath. It adds a second write port for load returns, same-cycle write-to-read bypass, a per-register busy scoreboard for outstanding loads, and a sequential bank-clear engine. It sits between the decode stage (read ports, busy query) and the ALU and memory writeback paths (write ports).

## Interface
- DATA_W, 19, register width in bits
- DEPTH, 8, number of registers (power of two, >= 2)
- ADDR_W, $clog2(DEPTH), register address width
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  read data (combinational)
- rd_busy1, rd_busy2  out  1  scoreboard bit of the addressed register
- wa_en, wa_addr, wa_data  in  1/ADDR_W/DATA_W  write port A (ALU, priority port)
- wb_en, wb_addr, wb_data  in  1/ADDR_W/DATA_W  write port B (load return)
- busy_set, busy_addr  in  1/ADDR_W  mark a register busy (load issued)
- clear_start  in  1  pulse: begin a full-bank clear
- clear_busy  out  1  high while a clear is in progress
- clear_done  out  1  one-cycle pulse when the clear completes
- wr_collision  out  1  one-cycle pulse: both write ports hit the same address

## Operation
- Reset: all registers 0, all busy bits 0, FSM IDLE, clear_busy/clear_done/wr_collision 0.
- Read: rd_dataN = reg[rd_addrN], overridden by the bypass value (below). With ZERO_REG=1 and address 0: data 0, busy 0, and no bypass.
- Write: at posedge, reg[wa_addr] <= wa_data if wa_en; reg[wb_addr] <= wb_data if wb_en.
- Collision: wa_en & wb_en & (wa_addr == wb_addr) → port A is written and port B is dropped; wr_collision pulses high for the next cycle. The busy bit of that address is still cleared.
- Bypass: if rd_addrN matches an enabled write address this cycle, rd_dataN returns that write data. Port A wins over port B.
- Scoreboard:
  - busy_set sets busy[busy_addr].
  - Any port-B write clears busy[wb_addr]; port-A writes do not touch busy bits.
  - Set and clear of the same register in the same cycle: set wins.
  - rd_busyN reflects the registered bits only and has no bypass.
- Clear FSM states are IDLE and CLEAR.
  - IDLE → CLEAR on clear_start; the internal counter loads 0.
  - In CLEAR, each cycle writes 0 to reg[cnt] and clears busy[cnt], then cnt increments.
  - When cnt == DEPTH-1 the FSM returns to IDLE and clear_done pulses in the following cycle.
  - clear_busy = (state == CLEAR).
  - While in CLEAR: wa_en, wb_en, busy_set and clear_start are ignored, bypass is disabled, and wr_collision is never raised.
  - Reads return stored contents, so partially cleared values are visible.
- Reset mid-clear: immediate return to IDLE with all state zeroed.

## Timing
- Read latency 0 (combinational from the address). Write-to-read is visible in the same cycle via bypass, and from storage the following cycle.
- Busy: busy_set in cycle t → rd_busy high from cycle t+1. A port-B write in cycle t → rd_busy low from t+1.
- Clear: clear_start sampled at edge t → clear_busy high for cycles t+1 .. t+DEPTH. clear_done is high in cycle t+DEPTH+1.
- Earliest accepted write after a clear: the cycle in which clear_done is high.
- wr_collision: 1-cycle registered pulse, cycle after the colliding edge.

## Structure
- Package regfile_pkg holds:
  - the default DATA_W/DEPTH constants;
  - the clear FSM state typedef (IDLE, CLEAR);
  - a function that computes the write-port priority select.
- Sub-module regfile_clear_seq contains the clear FSM, its ADDR_W counter, clear_busy and clear_done. It outputs a clear-write enable and a clear address to the bank.
- The bank array, scoreboard vector, bypass muxes and collision flop stay in the top module.

## Test plan
- Reset, then write 0x7FFFF to r3 via port A. Next cycle, read r3 on both ports → 0x7FFFF. Reading r5 → 0.
- Same cycle: port A writes r2=0x00011 and port B writes r2=0x00022, while rd_addr1=2. Expect rd_data1=0x00011 that cycle, r2=0x00011 afterwards, and wr_collision high exactly one cycle.
- busy_set r4 at t → rd_busy(r4)=1 at t+1. Port-B write r4=0x12345 at t+3 → busy 0 at t+4 and data 0x12345. Simultaneous busy_set r6 with a port-B write to r6 → busy stays 1.
- Fill all 8 registers, then pulse clear_start. Expect clear_busy high for 8 cycles and a port-A write during the clear to be dropped. clear_done pulses once at cycle 9, and all registers read 0 with busy 0.
- ZERO_REG=1: write 0x55555 to r0 → r0 reads 0, busy_set r0 → rd_busy 0.
- Assert rst in cycle 4 of a clear, with r7=0x1ABCD. Expect immediate clear_busy=0, and r7 reads 0 after reset releases.
